// File: rtl/aux_halt_ctrl_if.sv
// Run-control signal bundle between aux_halt_ctrl (slave) and its environment (master).
// btn_step is only consumed when AUX_HALT_STEP_EN is defined.
interface aux_halt_ctrl_if;
   logic        btn_resume;
   logic        btn_step;
   logic        syscall_halt;
   logic        en;
   logic        halt;
   logic        resume;
   logic [15:0] halt_cnt;
   logic        halted;

   modport slave (
      input  btn_resume, btn_step, syscall_halt, en,
      output halt, resume, halt_cnt, halted
   );

   modport master (
      output btn_resume, btn_step, syscall_halt, en,
      input  halt, resume, halt_cnt, halted
   );
endinterface

// File: rtl/aux_halt_ctrl.sv
// Halt/resume pulse generator with synchronised, debounced resume/step buttons.
// Optional single-step support is compiled in when AUX_HALT_STEP_EN is defined.
module aux_halt_ctrl_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_press
);
   // Toggle on the last of DEBOUNCE_CYCLES mismatching samples, so the
   // debounced level moves DEBOUNCE_CYCLES edges after the synchroniser output.
   localparam logic [23:0] LP_TERM = 24'(DEBOUNCE_CYCLES - 1);

   logic [1:0]  r_sync;
   logic        r_level;
   logic        r_level_d;
   logic [23:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync    <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync    <= {r_sync[0], i_raw};
         r_level_d <= r_level;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == LP_TERM) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 24'd1;
         end
      end
   end

   assign o_press = r_level & ~r_level_d;
endmodule

module aux_halt_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic           clk,
   input  logic           rst_n,
   aux_halt_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_RUN,
`ifdef AUX_HALT_STEP_EN
      ST_STEP,
`endif
      ST_HALTED
   } state_t;

   state_t      r_state;
   logic        r_halt;
   logic        r_resume;
   logic        r_halted;
   logic [15:0] r_halt_cnt;
   logic        w_resume_evt;

   aux_halt_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_resume (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (bus.btn_resume),
      .o_press (w_resume_evt)
   );

`ifdef AUX_HALT_STEP_EN
   logic w_step_evt;

   aux_halt_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (bus.btn_step),
      .o_press (w_step_evt)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_halt     <= 1'b0;
         r_resume   <= 1'b0;
         r_halted   <= 1'b0;
         r_halt_cnt <= '0;
      end else begin
         r_halt   <= 1'b0;
         r_resume <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (bus.syscall_halt && bus.en) begin
                  r_halt   <= 1'b1;
                  r_halted <= 1'b1;
                  r_state  <= ST_HALTED;
                  if (r_halt_cnt != '1) r_halt_cnt <= r_halt_cnt + 16'd1;
               end
            end
            ST_HALTED: begin
               // Resume takes priority; a simultaneous step press is dropped.
               if (w_resume_evt) begin
                  r_resume <= 1'b1;
                  r_halted <= 1'b0;
                  r_state  <= ST_RUN;
               end
`ifdef AUX_HALT_STEP_EN
               else if (w_step_evt) begin
                  r_resume <= 1'b1;
                  r_halted <= 1'b0;
                  r_state  <= ST_STEP;
               end
`endif
            end
`ifdef AUX_HALT_STEP_EN
            ST_STEP: begin
               if (bus.en) begin
                  r_halt   <= 1'b1;
                  r_halted <= 1'b1;
                  r_state  <= ST_HALTED;
                  if (r_halt_cnt != '1) r_halt_cnt <= r_halt_cnt + 16'd1;
               end
            end
`endif
            default: begin
               r_state  <= ST_RUN;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign bus.halt     = r_halt;
   assign bus.resume   = r_resume;
   assign bus.halted   = r_halted;
   assign bus.halt_cnt = r_halt_cnt;
endmodule

// File: tb/tb_aux_halt_ctrl.sv
// Directed bench for aux_halt_ctrl with DEBOUNCE_CYCLES=4; step scenarios depend on AUX_HALT_STEP_EN.
module tb_aux_halt_ctrl;
   localparam int DB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   exp_cnt = 0;
   int   nres;
   int   nhalt;

   aux_halt_ctrl_if bus ();

   aux_halt_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks_count(input int n, output int r, output int h);
      r = 0;
      h = 0;
      repeat (n) begin
         tick();
         r += int'(bus.resume);
         h += int'(bus.halt);
      end
   endtask

   task automatic do_halt(input string tag);
      bus.syscall_halt = 1'b1;
      tick();
      exp_cnt = (exp_cnt == 65535) ? 65535 : exp_cnt + 1;
      chk({tag, "_halt"}, 16'(bus.halt), 16'd1);
      chk({tag, "_resume_low"}, 16'(bus.resume), 16'd0);
      chk({tag, "_halted"}, 16'(bus.halted), 16'd1);
      chk({tag, "_cnt"}, bus.halt_cnt, 16'(exp_cnt));
      bus.syscall_halt = 1'b0;
      tick();
      chk({tag, "_halt_single"}, 16'(bus.halt), 16'd0);
   endtask

   // Button goes high before edge k; resume must appear exactly after edge k+DB+2.
   task automatic press_resume_exact(input string tag);
      int r, h;
      bus.btn_resume = 1'b1;
      ticks_count(DB + 2, r, h);
      chk({tag, "_no_early_resume"}, 16'(r), 16'd0);
      tick();
      chk({tag, "_resume"}, 16'(bus.resume), 16'd1);
      chk({tag, "_halt_low"}, 16'(bus.halt), 16'd0);
      chk({tag, "_run"}, 16'(bus.halted), 16'd0);
      ticks_count(20, r, h);
      chk({tag, "_held_one_event"}, 16'(r), 16'd0);
      bus.btn_resume = 1'b0;
      ticks_count(DB + 4, r, h);
      chk({tag, "_release_no_event"}, 16'(r), 16'd0);
   endtask

   initial begin
      bus.btn_resume   = 1'b0;
      bus.btn_step     = 1'b0;
      bus.syscall_halt = 1'b0;
      bus.en           = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_halt", 16'(bus.halt), 16'd0);
      chk("rst_resume", 16'(bus.resume), 16'd0);
      chk("rst_cnt", bus.halt_cnt, 16'd0);
      chk("rst_halted", 16'(bus.halted), 16'd0);
      rst_n = 1'b1;
      tick();

      // 1: syscall halt
      do_halt("t1");
      bus.syscall_halt = 1'b1;
      ticks_count(3, nres, nhalt);
      chk("t1_syscall_ignored_halted", 16'(nhalt), 16'd0);
      chk("t1_cnt_hold", bus.halt_cnt, 16'(exp_cnt));
      bus.syscall_halt = 1'b0;

      // 2: clean resume press
      press_resume_exact("t2");

      // 3: bounce then stable press
      do_halt("t3h");
      nres = 0;
      repeat (3) begin
         int r, h;
         bus.btn_resume = 1'b1;
         ticks_count(1, r, h);
         nres += r;
         bus.btn_resume = 1'b0;
         ticks_count(1, r, h);
         nres += r;
      end
      chk("t3_bounce_no_resume", 16'(nres), 16'd0);
      chk("t3_still_halted", 16'(bus.halted), 16'd1);
      press_resume_exact("t3");

      // 5: resume and step on the same edge
      do_halt("t5h");
      bus.btn_resume = 1'b1;
      bus.btn_step   = 1'b1;
      ticks_count(DB + 2, nres, nhalt);
      chk("t5_no_early_resume", 16'(nres), 16'd0);
      tick();
      chk("t5_resume", 16'(bus.resume), 16'd1);
      chk("t5_run", 16'(bus.halted), 16'd0);
      ticks_count(20, nres, nhalt);
      chk("t5_single_resume", 16'(nres), 16'd0);
      chk("t5_no_halt", 16'(nhalt), 16'd0);
      chk("t5_cnt", bus.halt_cnt, 16'(exp_cnt));
      bus.btn_resume = 1'b0;
      bus.btn_step   = 1'b0;
      ticks_count(DB + 4, nres, nhalt);

`ifdef AUX_HALT_STEP_EN
      // 4: single step; enable block raises en one cycle after resume
      do_halt("t4h");
      bus.en       = 1'b0;
      bus.btn_step = 1'b1;
      ticks_count(DB + 2, nres, nhalt);
      chk("t4_no_early_resume", 16'(nres), 16'd0);
      tick();
      chk("t4_resume", 16'(bus.resume), 16'd1);
      chk("t4_not_halted", 16'(bus.halted), 16'd0);
      tick();
      chk("t4_no_halt_before_en", 16'(bus.halt), 16'd0);
      chk("t4_resume_single", 16'(bus.resume), 16'd0);
      bus.en = 1'b1;
      tick();
      exp_cnt++;
      chk("t4_halt", 16'(bus.halt), 16'd1);
      chk("t4_halted", 16'(bus.halted), 16'd1);
      chk("t4_cnt", bus.halt_cnt, 16'(exp_cnt));
      ticks_count(20, nres, nhalt);
      chk("t4_held_no_resume", 16'(nres), 16'd0);
      chk("t4_one_halt", 16'(nhalt), 16'd1);
      bus.btn_step = 1'b0;
      ticks_count(DB + 4, nres, nhalt);
`else
      // Step button has no effect in this build
      do_halt("t4h");
      bus.btn_step = 1'b1;
      ticks_count(DB + 10, nres, nhalt);
      chk("t4_step_ignored", 16'(nres), 16'd0);
      chk("t4_stays_halted", 16'(bus.halted), 16'd1);
      bus.btn_step = 1'b0;
      ticks_count(DB + 4, nres, nhalt);
      press_resume_exact("t4r");
      do_halt("t4h2");
`endif
      chk("t6_cnt_five", bus.halt_cnt, 16'd5);
      chk("t6_halted_pre", 16'(bus.halted), 16'd1);

      // 6a: reset mid-debounce
      bus.btn_resume = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #2;
      chk("t6_rst_halt", 16'(bus.halt), 16'd0);
      chk("t6_rst_resume", 16'(bus.resume), 16'd0);
      chk("t6_rst_cnt", bus.halt_cnt, 16'd0);
      chk("t6_rst_halted", 16'(bus.halted), 16'd0);
      #1;
      rst_n = 1'b1;
      exp_cnt = 0;
      ticks_count(20, nres, nhalt);
      chk("t6_no_resume_after_rst", 16'(nres), 16'd0);
      chk("t6_no_halt_after_rst", 16'(nhalt), 16'd0);
      chk("t6_run_after_rst", 16'(bus.halted), 16'd0);
      bus.btn_resume = 1'b0;
      ticks_count(DB + 4, nres, nhalt);

      // 6b: saturation, counter preloaded close to the limit
      force dut.r_halt_cnt = 16'hFFFB;
      tick();
      release dut.r_halt_cnt;
      exp_cnt = 16'hFFFB;
      for (int i = 0; i < 6; i++) begin
         do_halt($sformatf("sat%0d", i));
         press_resume_exact($sformatf("satr%0d", i));
      end
      chk("sat_final", bus.halt_cnt, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
